// File: rtl/cs_if.sv
// Call-stack control bundle: request/response and register-file strobes.
// The slave modport is the call_stack_ctrl side.
interface cs_if #(
    parameter int PC_WIDTH = 5
);
    logic                cs_call;
    logic                cs_ret;
    logic [PC_WIDTH-1:0] cs_ret_addr_in;
    logic                cs_err_clr;
    logic                cs_ready;
    logic                cs_pc_load;
    logic [PC_WIDTH-1:0] cs_pc_out;
    logic                rf_stack_push;
    logic                rf_stack_pop;
    logic [PC_WIDTH-1:0] rf_stack_pointer;
    logic                cs_overflow;
    logic                cs_underflow;

    modport slave (
        input  cs_call, cs_ret, cs_ret_addr_in, cs_err_clr,
        output cs_ready, cs_pc_load, cs_pc_out,
        output rf_stack_push, rf_stack_pop, rf_stack_pointer,
        output cs_overflow, cs_underflow
    );

    modport master (
        output cs_call, cs_ret, cs_ret_addr_in, cs_err_clr,
        input  cs_ready, cs_pc_load, cs_pc_out,
        input  rf_stack_push, rf_stack_pop, rf_stack_pointer,
        input  cs_overflow, cs_underflow
    );
endinterface

// File: rtl/call_stack_ctrl.sv
// Return-address stack sequencer with register-file context strobes.
// Define CS_ERR_TRAP_EN for sticky error flags that stall cs_ready.
module call_stack_ctrl #(
    parameter int PC_WIDTH = 5,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8
) (
    input logic clk,
    input logic rst_n,
    cs_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_WIDTH-1:0] SP_MAX = PC_WIDTH'(DEPTH);
    localparam logic [PC_WIDTH-1:0] SP_ONE = PC_WIDTH'(1);

    if (DEPTH < 1 || DEPTH >= (1 << PC_WIDTH) || WIDTH < 1) begin : g_bad_cfg
        $error("call_stack_ctrl: invalid DEPTH/PC_WIDTH/WIDTH");
    end

    typedef enum logic [1:0] {IDLE, PUSH, POP, LOAD} state_t;

    state_t              state, nxt;
    logic [PC_WIDTH-1:0] sp, sp_dec, pc_q;
    logic [PC_WIDTH-1:0] ret_mem [2**AW];
    logic                ovf_q, unf_q;
    logic                err_hold, accept, full, empty;
    logic                push_req, pop_req, ovf_set, unf_set;

`ifdef CS_ERR_TRAP_EN
    assign err_hold = ovf_q | unf_q;
`else
    assign err_hold = 1'b0;
`endif

    assign accept   = (state == IDLE) && !err_hold;
    assign full     = sp >= SP_MAX;
    assign empty    = sp == '0;
    assign sp_dec   = sp - SP_ONE;
    assign push_req = accept && bus.cs_call && !full;
    assign pop_req  = accept && !bus.cs_call && bus.cs_ret && !empty;
    assign ovf_set  = accept && bus.cs_call && full;
    assign unf_set  = accept && !bus.cs_call && bus.cs_ret && empty;

    // State register; reset aborts any in-flight push/pop/load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state: call wins over return, busy cycles ignore requests.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (push_req)     nxt = PUSH;
                else if (pop_req) nxt = POP;
            end
            PUSH:    nxt = IDLE;
            POP:     nxt = LOAD;
            LOAD:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Stack pointer moves after the strobe; PC is fetched as SP drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp   <= '0;
            pc_q <= '0;
        end else begin
            if (state == PUSH) sp <= sp + SP_ONE;
            if (state == POP) begin
                sp   <= sp_dec;
                pc_q <= ret_mem[sp_dec[AW-1:0]];
            end
        end
    end

    // Return-address storage, written when a call is accepted.
    always_ff @(posedge clk) begin
        if (push_req) ret_mem[sp[AW-1:0]] <= bus.cs_ret_addr_in;
    end

    // Error flags: a new error always beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
`ifdef CS_ERR_TRAP_EN
            ovf_q <= ovf_set | (ovf_q & ~bus.cs_err_clr);
            unf_q <= unf_set | (unf_q & ~bus.cs_err_clr);
`else
            ovf_q <= ovf_set;
            unf_q <= unf_set;
`endif
        end
    end

    assign bus.cs_ready         = accept;
    assign bus.rf_stack_push    = state == PUSH;
    assign bus.rf_stack_pop     = state == POP;
    assign bus.cs_pc_load       = state == LOAD;
    assign bus.cs_pc_out        = pc_q;
    assign bus.rf_stack_pointer = sp;
    assign bus.cs_overflow      = ovf_q;
    assign bus.cs_underflow     = unf_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: directed scenarios plus random traffic
// against a queue-based schedule model.
module tb_call_stack_ctrl;
    localparam int PW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
`ifdef CS_ERR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int EV_NONE = 0;
    localparam int EV_PUSH = 1;
    localparam int EV_POP  = 2;
    localparam int EV_LOAD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cs_if #(.PC_WIDTH(PW)) bus ();

    call_stack_ctrl #(
        .PC_WIDTH(PW),
        .WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: event in the current cycle, events scheduled after it,
    // and the stack as a queue of saved return addresses.
    int          m_ev;
    int          m_sp;
    logic [PW-1:0] m_pc;
    bit          m_ovf, m_unf;
    int          m_stk[$];
    int          m_pend[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        return (m_ev == EV_NONE) && !(TRAP && (m_ovf || m_unf));
    endfunction

    task automatic model_reset();
        m_ev  = EV_NONE;
        m_sp  = 0;
        m_pc  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stk.delete();
        m_pend.delete();
    endtask

    task automatic check_now();
        chk("ready", 32'(bus.cs_ready), 32'(m_rdy()));
        chk("push", 32'(bus.rf_stack_push), 32'(m_ev == EV_PUSH));
        chk("pop", 32'(bus.rf_stack_pop), 32'(m_ev == EV_POP));
        chk("pc_load", 32'(bus.cs_pc_load), 32'(m_ev == EV_LOAD));
        chk("sp", 32'(bus.rf_stack_pointer), m_sp);
        chk("pc_out", 32'(bus.cs_pc_out), 32'(m_pc));
        chk("overflow", 32'(bus.cs_overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.cs_underflow), 32'(m_unf));
    endtask

    // Called at a falling edge: check this cycle, advance the model
    // across the next rising edge, drive the inputs for it.
    task automatic step(bit c, bit r, logic [PW-1:0] a, bit clr);
        bit rdy;
        bit oset;
        bit uset;
        int nev;
        check_now();
        rdy  = m_rdy();
        oset = 1'b0;
        uset = 1'b0;
        nev  = EV_NONE;
        if (m_ev == EV_PUSH) m_sp++;
        if (m_ev == EV_POP) begin
            m_sp--;
            m_pc = PW'(m_stk.pop_back());
        end
        if (m_pend.size() > 0) begin
            nev = m_pend.pop_front();
        end else if (rdy && c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(int'(a));
                nev = EV_PUSH;
            end else begin
                oset = 1'b1;
            end
        end else if (rdy && r) begin
            if (m_stk.size() > 0) begin
                nev = EV_POP;
                m_pend.push_back(EV_LOAD);
            end else begin
                uset = 1'b1;
            end
        end
        if (TRAP) begin
            m_ovf = oset || (m_ovf && !clr);
            m_unf = uset || (m_unf && !clr);
        end else begin
            m_ovf = oset;
            m_unf = uset;
        end
        m_ev = nev;
        bus.cs_call        = c;
        bus.cs_ret         = r;
        bus.cs_ret_addr_in = a;
        bus.cs_err_clr     = clr;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_call(logic [PW-1:0] a);
        step(1'b1, 1'b0, a, 1'b0);
        idle(1);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b1, '0, 1'b0);
        idle(2);
    endtask

    // Asynchronous reset in the middle of a cycle, released at a falling edge.
    task automatic async_reset(string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_push"}, 32'(bus.rf_stack_push), 32'd0);
        chk({tag, "_rst_pop"}, 32'(bus.rf_stack_pop), 32'd0);
        chk({tag, "_rst_load"}, 32'(bus.cs_pc_load), 32'd0);
        chk({tag, "_rst_sp"}, 32'(bus.rf_stack_pointer), 32'd0);
        chk({tag, "_rst_ready"}, 32'(bus.cs_ready), 32'd1);
        bus.cs_call    = 1'b0;
        bus.cs_ret     = 1'b0;
        bus.cs_err_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        bus.cs_call        = 1'b0;
        bus.cs_ret         = 1'b0;
        bus.cs_ret_addr_in = '0;
        bus.cs_err_clr     = 1'b0;
        #1;
        check_now();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_call(PW'(5));
        do_call(PW'(9));
        do_call(PW'(17));
        do_ret();
        do_ret();
        do_ret();
        chk("nest_sp_end", 32'(bus.rf_stack_pointer), 32'd0);

        do_call(PW'(3));
        chk("single_call_sp", 32'(bus.rf_stack_pointer), 32'd1);
        do_ret();

        for (int i = 0; i < DEPTH; i++) do_call(PW'(i + 11));
        step(1'b1, 1'b0, PW'(30), 1'b0);
        idle(2);
        chk("ovf_sp_held", 32'(bus.rf_stack_pointer), 32'(DEPTH));
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) do_ret();

        step(1'b0, 1'b1, '0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);

        do_call(PW'(21));
        step(1'b1, 1'b1, PW'(22), 1'b0);
        idle(2);
        chk("both_sp", 32'(bus.rf_stack_pointer), 32'd2);

        step(1'b0, 1'b1, '0, 1'b0);
        check_now();
        async_reset("pop");
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            bit c;
            bit r;
            bit clr;
            int pc = ((i / 150) % 2 == 1) ? 20 : 60;
            int pr = ((i / 150) % 2 == 1) ? 60 : 20;
            c   = $urandom_range(99) < pc;
            r   = $urandom_range(99) < pr;
            clr = $urandom_range(99) < 10;
            if ($urandom_range(299) == 0) begin
                check_now();
                async_reset("rnd");
            end else begin
                step(c, r, PW'($urandom), clr);
            end
        end
        check_now();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 5, giving the program-counter and stack-pointer width.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width of the register file it serves.
REQ-003 The block SHALL have parameter DEPTH, default 8, giving the maximum nesting depth; DEPTH < 2**PC_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cs_call, input, 1 bit: call request, sampled only while cs_ready=1.
REQ-007 The block SHALL have port cs_ret, input, 1 bit: return request, sampled only while cs_ready=1.
REQ-008 The block SHALL have port cs_ret_addr_in, input, PC_WIDTH bits: return address to save on a call.
REQ-009 The block SHALL have port cs_err_clr, input, 1 bit: clears error flags.
REQ-010 The block SHALL have port cs_ready, output, 1 bit: idle and able to accept a request.
REQ-011 The block SHALL have port cs_pc_load, output, 1 bit: one-cycle PC reload strobe.
REQ-012 The block SHALL have port cs_pc_out, output, PC_WIDTH bits: restored return address.
REQ-013 The block SHALL have port rf_stack_push, output, 1 bit: register-file context save strobe.
REQ-014 The block SHALL have port rf_stack_pop, output, 1 bit: register-file context restore strobe.
REQ-015 The block SHALL have port rf_stack_pointer, output, PC_WIDTH bits: current stack pointer SP (entry count).
REQ-016 The block SHALL have port cs_overflow, output, 1 bit: call attempted at full stack.
REQ-017 The block SHALL have port cs_underflow, output, 1 bit: return attempted at empty stack.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, PUSH, POP, LOAD; cs_ready=1 only in IDLE.
REQ-019 In IDLE with cs_call=1 and SP<DEPTH, the block SHALL write cs_ret_addr_in to ret_mem[SP] and go to PUSH.
REQ-020 In PUSH, the block SHALL assert rf_stack_push=1 for exactly one cycle with rf_stack_pointer=SP, then set SP<=SP+1 and go to IDLE.
REQ-021 In IDLE with cs_ret=1 and SP>0, the block SHALL go to POP.
REQ-022 In POP, the block SHALL assert rf_stack_pop=1 for exactly one cycle with rf_stack_pointer=SP (always >=1), then set SP<=SP-1 and go to LOAD.
REQ-023 In LOAD, the block SHALL assert cs_pc_load=1 for one cycle with cs_pc_out=ret_mem[SP] (the decremented SP), then go to IDLE.
REQ-024 Latency SHALL be: call accepted cycle N -> push at N+1 -> ready at N+2; return accepted at N -> pop at N+1 -> pc_load at N+2 -> ready at N+3.
REQ-025 When cs_call and cs_ret are both asserted in IDLE, the call SHALL take priority and the return SHALL be dropped.
REQ-026 Requests arriving while cs_ready=0 SHALL be ignored and not queued.
REQ-027 A call at SP==DEPTH SHALL leave SP unchanged, issue no push, and set cs_overflow.
REQ-028 A return at SP==0 SHALL issue no pop and no pc_load, and set cs_underflow.
REQ-029 rf_stack_push, rf_stack_pop and cs_pc_load SHALL be mutually exclusive in every cycle.
REQ-030 cs_pc_out SHALL hold its last value outside LOAD.
REQ-031 cs_err_clr=1 SHALL clear cs_overflow and cs_underflow on the next edge; a simultaneous new error SHALL win over the clear.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, SP=0, cs_ready=1, and all other outputs =0 (including cs_pc_out, cs_overflow, cs_underflow).
REQ-033 Reset asserted during PUSH, POP or LOAD SHALL abort the operation with no strobe emitted afterward.
REQ-034 ret_mem contents SHALL NOT be reset and SHALL NOT be observable at SP=0.

Configuration
REQ-035 With macro CS_ERR_TRAP_EN defined, cs_overflow and cs_underflow SHALL be sticky and cs_ready SHALL be held 0 while either is set, until cs_err_clr.
REQ-036 Without CS_ERR_TRAP_EN, each error flag SHALL be a one-cycle pulse, cs_ready SHALL be unaffected, and cs_err_clr SHALL have no effect.

Verification
REQ-037 Reset, then 3 calls with addresses 5, 9, 17, then 3 returns -> cs_pc_out sequence 17, 9, 5 with one cs_pc_load each; SP ends at 0.
REQ-038 Call with address 3 -> rf_stack_push high for exactly one cycle with rf_stack_pointer=0; SP=1 afterward; cs_ready low for 1 cycle.
REQ-039 Perform 8 calls, then a 9th -> cs_overflow=1 and no rf_stack_push; SP remains 8.
REQ-040 Return at SP=0 -> cs_underflow=1, no rf_stack_pop, no cs_pc_load; with CS_ERR_TRAP_EN, cs_ready=0 until cs_err_clr.
REQ-041 cs_call and cs_ret asserted together at SP=1 -> push occurs and SP=2; no pop.
REQ-042 rst_n driven low during POP -> rf_stack_pop drops immediately, no cs_pc_load follows, SP=0.
